// File: rtl/game_scorer.sv
// game_scorer -- round-based guessing game controller.
//
// The player matches three 2-bit target symbols with three 2-bit switch
// values and presses submit. Each round with all three slots matching scores
// one point (BCD, saturating at 99). A BCD countdown of GAME_SECONDS runs
// while a game is active, and the game ends when it reaches 00.
//
// Parameters:
//   GAME_SECONDS  game length in seconds (1..99)
//   SHOW_SECONDS  tick_1hz pulses the round result is held (1..15)
//
// Ports:
//   clk                      clock, rising edge
//   reset                    synchronous, active-high
//   tick_1hz                 one-cycle pulse per second
//   submit                   push-button level (active high)
//   target1..3               current random symbols
//   guess1..3                player switch values
//   match                    registered per-slot compare result, bit0 = slot1
//   new_round                one-cycle pulse requesting fresh targets
//   game_over                high while in OVER
//   score_tens, score_ones   BCD score
//   time_tens, time_ones     BCD seconds remaining
//   state                    IDLE=0 PLAY=1 CHECK=2 SHOW=3 OVER=4
module game_scorer #(
  parameter int unsigned GAME_SECONDS = 60,
  parameter int unsigned SHOW_SECONDS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       submit,
  input  logic [1:0] target1,
  input  logic [1:0] target2,
  input  logic [1:0] target3,
  input  logic [1:0] guess1,
  input  logic [1:0] guess2,
  input  logic [1:0] guess3,
  output logic [2:0] match,
  output logic       new_round,
  output logic       game_over,
  output logic [3:0] score_tens,
  output logic [3:0] score_ones,
  output logic [3:0] time_tens,
  output logic [3:0] time_ones,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAY  = 3'd1,
    S_CHECK = 3'd2,
    S_SHOW  = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam logic [3:0] GAME_TENS = 4'(GAME_SECONDS / 10);
  localparam logic [3:0] GAME_ONES = 4'(GAME_SECONDS % 10);
  localparam logic [3:0] SHOW_LAST = 4'(SHOW_SECONDS - 1);

  state_t     cur_state;
  state_t     next_state;
  logic       submit_q;
  logic       press;
  logic       active;
  logic       timeout;
  logic       show_last;
  logic [2:0] hit;
  logic [3:0] show_cnt;
  logic [1:0] cap_t1, cap_t2, cap_t3;
  logic [1:0] cap_g1, cap_g2, cap_g3;

  assign state = cur_state;

  always_comb begin
    press     = submit & ~submit_q;
    active    = (cur_state == S_PLAY) || (cur_state == S_CHECK) ||
                (cur_state == S_SHOW);
    // Only the tick that takes 01 -> 00 ends the game.
    timeout   = tick_1hz && active && (time_tens == 4'd0) && (time_ones == 4'd1);
    show_last = tick_1hz && (show_cnt == SHOW_LAST);
    hit[0]    = (cap_g1 == cap_t1);
    hit[1]    = (cap_g2 == cap_t2);
    hit[2]    = (cap_g3 == cap_t3);
  end

  always_comb begin
    next_state = cur_state;
    unique case (cur_state)
      S_IDLE:  if (press) next_state = S_PLAY;
      S_PLAY: begin
        // A timeout in the same cycle as a press discards the guess.
        if (timeout)    next_state = S_OVER;
        else if (press) next_state = S_CHECK;
      end
      S_CHECK: next_state = timeout ? S_OVER : S_SHOW;
      S_SHOW: begin
        if (timeout)        next_state = S_OVER;
        else if (show_last) next_state = S_PLAY;
      end
      S_OVER:  if (press) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state <= S_IDLE;
      submit_q  <= 1'b1;
      game_over <= 1'b0;
      new_round <= 1'b0;
      match     <= '0;
      show_cnt  <= '0;
    end else begin
      cur_state <= next_state;
      submit_q  <= submit;
      game_over <= (next_state == S_OVER);
      // Entering PLAY from anywhere else is exactly the fresh-target request.
      new_round <= (next_state == S_PLAY) && (cur_state != S_PLAY);

      if (cur_state == S_IDLE && press)
        match <= '0;
      else if (cur_state == S_CHECK)
        match <= hit;
      else if (cur_state == S_SHOW && show_last && !timeout)
        match <= '0;

      if (cur_state == S_CHECK)
        show_cnt <= '0;
      else if (cur_state == S_SHOW && tick_1hz)
        show_cnt <= show_last ? '0 : show_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      score_tens <= '0;
      score_ones <= '0;
      time_tens  <= GAME_TENS;
      time_ones  <= GAME_ONES;
    end else begin
      if (cur_state == S_IDLE && press) begin
        score_tens <= '0;
        score_ones <= '0;
      end else if (cur_state == S_CHECK && (&hit)) begin
        if (score_ones != 4'd9) begin
          score_ones <= score_ones + 4'd1;
        end else if (score_tens != 4'd9) begin
          score_ones <= '0;
          score_tens <= score_tens + 4'd1;
        end
      end

      if (cur_state == S_IDLE && press) begin
        time_tens <= GAME_TENS;
        time_ones <= GAME_ONES;
      end else if (active && tick_1hz) begin
        if (time_ones != 4'd0) begin
          time_ones <= time_ones - 4'd1;
        end else if (time_tens != 4'd0) begin
          time_ones <= 4'd9;
          time_tens <= time_tens - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cap_t1 <= '0;
      cap_t2 <= '0;
      cap_t3 <= '0;
      cap_g1 <= '0;
      cap_g2 <= '0;
      cap_g3 <= '0;
    end else if (cur_state == S_PLAY && press && !timeout) begin
      cap_t1 <= target1;
      cap_t2 <= target2;
      cap_t3 <= target3;
      cap_g1 <= guess1;
      cap_g2 <= guess2;
      cap_g3 <= guess3;
    end
  end

endmodule

// File: tb/tb_game_scorer.sv
// Directed bench for game_scorer: a vector table per cycle on a default
// instance (60 s game, 1 s show) plus hand-written sequences for the score
// carry and for timeouts on a short-game instance (2 s game, 2 s show).
module tb_game_scorer;

  logic       clk = 1'b0;
  logic       reset, tick_1hz, submit;
  logic [1:0] target1, target2, target3, guess1, guess2, guess3;

  logic [2:0] a_match, b_match, a_state, b_state;
  logic       a_nr, b_nr, a_go, b_go;
  logic [3:0] a_st, a_so, a_tt, a_to, b_st, b_so, b_tt, b_to;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  game_scorer #(.GAME_SECONDS(60), .SHOW_SECONDS(1)) dut_a (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .submit(submit),
    .target1(target1), .target2(target2), .target3(target3),
    .guess1(guess1), .guess2(guess2), .guess3(guess3),
    .match(a_match), .new_round(a_nr), .game_over(a_go),
    .score_tens(a_st), .score_ones(a_so),
    .time_tens(a_tt), .time_ones(a_to), .state(a_state)
  );

  game_scorer #(.GAME_SECONDS(2), .SHOW_SECONDS(2)) dut_b (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .submit(submit),
    .target1(target1), .target2(target2), .target3(target3),
    .guess1(guess1), .guess2(guess2), .guess3(guess3),
    .match(b_match), .new_round(b_nr), .game_over(b_go),
    .score_tens(b_st), .score_ones(b_so),
    .time_tens(b_tt), .time_ones(b_to), .state(b_state)
  );

  typedef struct {
    logic       rst, sub, tck;
    logic [1:0] t1, t2, t3, g1, g2, g3;
    logic [2:0] st;
    logic [2:0] m;
    logic       nr, go;
    int         sc, tm;
  } vec_t;

  vec_t tbl[24];

  function automatic vec_t mk(logic r, logic s, logic k,
                              logic [1:0] t1, logic [1:0] t2, logic [1:0] t3,
                              logic [1:0] g1, logic [1:0] g2, logic [1:0] g3,
                              logic [2:0] st, logic [2:0] m, logic nr, logic go,
                              int sc, int tm);
    vec_t v;
    v.rst = r; v.sub = s; v.tck = k;
    v.t1 = t1; v.t2 = t2; v.t3 = t3;
    v.g1 = g1; v.g2 = g2; v.g3 = g3;
    v.st = st; v.m = m; v.nr = nr; v.go = go; v.sc = sc; v.tm = tm;
    return v;
  endfunction

  task automatic cyc(input logic r, input logic s, input logic k);
    reset = r; submit = s; tick_1hz = k;
    @(posedge clk);
    #1;
  endtask

  task automatic set_tg(input logic [1:0] t1, input logic [1:0] t2, input logic [1:0] t3,
                        input logic [1:0] g1, input logic [1:0] g2, input logic [1:0] g3);
    target1 = t1; target2 = t2; target3 = t3;
    guess1 = g1; guess2 = g2; guess3 = g3;
  endtask

  task automatic chk(input string name, input bit which,
                     input logic [2:0] st, input logic [2:0] m,
                     input logic nr, input logic go, input int sc, input int tm);
    logic [23:0] got, want;
    want = {st, m, nr, go, 4'(sc / 10), 4'(sc % 10), 4'(tm / 10), 4'(tm % 10)};
    if (which)
      got = {b_state, b_match, b_nr, b_go, b_st, b_so, b_tt, b_to};
    else
      got = {a_state, a_match, a_nr, a_go, a_st, a_so, a_tt, a_to};
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got state=%0d match=%b nr=%b go=%b score=%h time=%h, want state=%0d match=%b nr=%b go=%b score=%h time=%h",
               name, got[23:21], got[20:18], got[17], got[16], got[15:8], got[7:0],
               want[23:21], want[20:18], want[17], want[16], want[15:8], want[7:0]);
    end
  endtask

  initial begin
    reset = 1'b1; submit = 1'b0; tick_1hz = 1'b0;
    set_tg(0, 0, 0, 0, 0, 0);

    //               rst sub tck  t1 t2 t3  g1 g2 g3  st m  nr go sc tm
    tbl[0]  = mk(1, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 60);
    tbl[1]  = mk(0, 0, 1,  0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 60);
    tbl[2]  = mk(0, 1, 0,  0, 0, 0,  0, 0, 0,  1, 0, 1, 0, 0, 60);
    tbl[3]  = mk(0, 1, 0,  0, 0, 0,  0, 0, 0,  1, 0, 0, 0, 0, 60);
    tbl[4]  = mk(0, 0, 0,  0, 1, 2,  0, 1, 2,  1, 0, 0, 0, 0, 60);
    tbl[5]  = mk(0, 1, 0,  0, 1, 2,  0, 1, 2,  2, 0, 0, 0, 0, 60);
    tbl[6]  = mk(0, 0, 0,  0, 1, 2,  0, 1, 2,  3, 7, 0, 0, 1, 60);
    tbl[7]  = mk(0, 1, 0,  0, 1, 2,  0, 1, 2,  3, 7, 0, 0, 1, 60);
    tbl[8]  = mk(0, 0, 1,  0, 1, 2,  0, 1, 2,  1, 0, 1, 0, 1, 59);
    tbl[9]  = mk(0, 0, 0,  2, 2, 2,  2, 0, 2,  1, 0, 0, 0, 1, 59);
    tbl[10] = mk(0, 1, 0,  2, 2, 2,  2, 0, 2,  2, 0, 0, 0, 1, 59);
    tbl[11] = mk(0, 0, 0,  2, 2, 2,  2, 0, 2,  3, 5, 0, 0, 1, 59);
    tbl[12] = mk(0, 0, 1,  2, 2, 2,  2, 0, 2,  1, 0, 1, 0, 1, 58);
    tbl[13] = mk(0, 0, 0,  3, 0, 1,  3, 3, 1,  1, 0, 0, 0, 1, 58);
    tbl[14] = mk(0, 1, 0,  3, 0, 1,  3, 3, 1,  2, 0, 0, 0, 1, 58);
    tbl[15] = mk(0, 0, 0,  3, 0, 1,  3, 3, 1,  3, 5, 0, 0, 1, 58);
    tbl[16] = mk(0, 0, 1,  3, 0, 1,  3, 3, 1,  1, 0, 1, 0, 1, 57);
    tbl[17] = mk(0, 1, 0,  3, 3, 3,  3, 3, 3,  2, 0, 0, 0, 1, 57);
    tbl[18] = mk(0, 0, 0,  3, 3, 3,  3, 3, 3,  3, 7, 0, 0, 2, 57);
    tbl[19] = mk(1, 1, 1,  3, 3, 3,  3, 3, 3,  0, 0, 0, 0, 0, 60);
    tbl[20] = mk(0, 1, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 60);
    tbl[21] = mk(0, 1, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 60);
    tbl[22] = mk(0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 60);
    tbl[23] = mk(0, 1, 0,  0, 0, 0,  0, 0, 0,  1, 0, 1, 0, 0, 60);

    for (int i = 0; i < 24; i++) begin
      set_tg(tbl[i].t1, tbl[i].t2, tbl[i].t3, tbl[i].g1, tbl[i].g2, tbl[i].g3);
      cyc(tbl[i].rst, tbl[i].sub, tbl[i].tck);
      chk($sformatf("vec%0d", i), 1'b0, tbl[i].st, tbl[i].m, tbl[i].nr,
          tbl[i].go, tbl[i].sc, tbl[i].tm);
    end

    // Ten correct rounds on the long game: BCD carry 09 -> 10.
    set_tg(1, 1, 1, 1, 1, 1);
    for (int r = 0; r < 10; r++) begin
      cyc(0, 0, 0);
      cyc(0, 1, 0);
      cyc(0, 0, 0);
      chk($sformatf("round%0d_show", r), 1'b0, 3, 7, 0, 0, r + 1, 60 - r);
      cyc(0, 0, 1);
      chk($sformatf("round%0d_next", r), 1'b0, 1, 0, 1, 0, r + 1, 59 - r);
    end

    // Short game: timeout coincident with a press in PLAY.
    set_tg(0, 0, 0, 1, 1, 1);
    cyc(1, 0, 0);
    chk("b_reset", 1'b1, 0, 0, 0, 0, 0, 2);
    cyc(0, 0, 0);
    cyc(0, 1, 0);
    chk("b_start", 1'b1, 1, 0, 1, 0, 0, 2);
    cyc(0, 0, 1);
    chk("b_tick1", 1'b1, 1, 0, 0, 0, 0, 1);
    cyc(0, 1, 1);
    chk("b_press_timeout", 1'b1, 4, 0, 0, 1, 0, 0);
    cyc(0, 0, 1);
    chk("b_over_hold", 1'b1, 4, 0, 0, 1, 0, 0);
    cyc(0, 1, 0);
    chk("b_over_exit", 1'b1, 0, 0, 0, 0, 0, 0);

    // Timeout tick while in CHECK: scoring still completes.
    set_tg(2, 2, 2, 2, 2, 2);
    cyc(0, 0, 0);
    cyc(0, 1, 0);
    chk("b_start2", 1'b1, 1, 0, 1, 0, 0, 2);
    cyc(0, 0, 1);
    cyc(0, 1, 0);
    chk("b_check", 1'b1, 2, 0, 0, 0, 0, 1);
    cyc(0, 0, 1);
    chk("b_check_timeout", 1'b1, 4, 7, 0, 1, 1, 0);
    cyc(0, 1, 0);
    chk("b_idle_hold", 1'b1, 0, 7, 0, 0, 1, 0);

    // Timeout on the final SHOW tick: no new_round.
    cyc(0, 0, 0);
    cyc(0, 1, 0);
    chk("b_start3", 1'b1, 1, 0, 1, 0, 0, 2);
    cyc(0, 0, 0);
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    chk("b_show", 1'b1, 3, 7, 0, 0, 1, 2);
    cyc(0, 0, 1);
    chk("b_show_tick1", 1'b1, 3, 7, 0, 0, 1, 1);
    cyc(0, 0, 1);
    chk("b_show_timeout", 1'b1, 4, 7, 0, 1, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
